// File: rtl/mmio_console_uart_pkg.sv
// Shared constants and types for the MMIO console / finish peripheral.
package mmio_console_uart_pkg;

    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0020_0000;
    localparam logic [31:0] FINISH_ADDR_DEF  = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/mmio_console_uart_sync_fifo.sv
// Synchronous FIFO with show-ahead read: o_rdata always presents the head entry.
module mmio_console_uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_console_uart.sv
// Console byte sink on the DCCM store port: FIFO-buffered 8N1 UART transmitter
// plus a sticky end-of-test flag with exit code.
module mmio_console_uart
    import mmio_console_uart_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [XLEN-1:0] FINISH_ADDR  = FINISH_ADDR_DEF,
    parameter int unsigned     FIFO_DEPTH   = 16,
    parameter int unsigned     CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            dccm_wen,
    input  logic [XLEN-1:0] dccm_waddr,
    input  logic [XLEN-1:0] dccm_wdata,
    output logic            console_stall,
    output logic            uart_tx,
    output logic            tx_busy,
    output logic            overflow,
    output logic            finish,
    output logic [XLEN-1:0] finish_code
);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_e       r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_uart_tx;
    logic              r_overflow;
    logic              r_finish;
    logic [XLEN-1:0]   r_finish_code;

    logic              w_console_hit;
    logic              w_finish_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [7:0]        w_head;
    logic [CW-1:0]     w_count;
    logic              w_baud_tc;

    assign w_console_hit = dccm_wen && (dccm_waddr == CONSOLE_ADDR);
    assign w_finish_hit  = dccm_wen && (dccm_waddr == FINISH_ADDR);
    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign w_push        = w_console_hit & ~w_full;
    assign w_pop         = (r_state == IDLE) & ~w_empty;
    assign w_baud_tc     = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    mmio_console_uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (dccm_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow    <= 1'b0;
            r_finish      <= 1'b0;
            r_finish_code <= '0;
        end else begin
            if (w_console_hit && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_finish_hit && !r_finish) begin
                r_finish      <= 1'b1;
                r_finish_code <= dccm_wdata;
            end
        end
    end

    // uart_tx is registered alongside the state so it changes with the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_uart_tx <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_uart_tx <= 1'b1;
                    r_baud    <= '0;
                    if (!w_empty) begin
                        r_shift   <= w_head;
                        r_state   <= START;
                        r_uart_tx <= 1'b0;
                    end
                end
                START: begin
                    if (w_baud_tc) begin
                        r_state   <= DATA;
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_uart_tx <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_tc) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= STOP;
                            r_uart_tx <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_uart_tx <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    r_uart_tx <= 1'b1;
                    if (w_baud_tc) begin
                        r_state <= IDLE;
                        r_baud  <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign console_stall = w_full;
    assign uart_tx       = r_uart_tx;
    assign tx_busy       = (w_count != '0) | (r_state != IDLE);
    assign overflow      = r_overflow;
    assign finish        = r_finish;
    assign finish_code   = r_finish_code;

endmodule

// File: tb/tb_mmio_console_uart.sv
// Self-checking bench: queue/timeline model of the console UART compared every cycle,
// a mid-bit UART receiver, and directed literal checks.
module tb_mmio_console_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] CA = 32'h0020_0000;
    localparam logic [31:0] FA = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dccm_wen = 1'b0;
    logic [31:0] dccm_waddr = '0;
    logic [31:0] dccm_wdata = '0;
    logic        console_stall;
    logic        uart_tx;
    logic        tx_busy;
    logic        overflow;
    logic        finish;
    logic [31:0] finish_code;

    mmio_console_uart #(
        .XLEN         (32),
        .CONSOLE_ADDR (CA),
        .FINISH_ADDR  (FA),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .dccm_wen      (dccm_wen),
        .dccm_waddr    (dccm_waddr),
        .dccm_wdata    (dccm_wdata),
        .console_stall (console_stall),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .overflow      (overflow),
        .finish        (finish),
        .finish_code   (finish_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: byte queue plus the frame in flight as (byte, cycles elapsed).
    logic [7:0]  m_q[$];
    bit          m_active = 0;
    int          m_t = 0;
    logic [7:0]  m_byte = '0;
    bit          m_ovf = 0;
    bit          m_fin = 0;
    logic [31:0] m_code = '0;
    bit          m_valid = 0;

    logic [7:0]  rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        bit full;
        bit pop;
        if (!rstn) begin
            m_q.delete();
            m_active = 0;
            m_t      = 0;
            m_ovf    = 0;
            m_fin    = 0;
            m_code   = '0;
            m_valid  = 1;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = !m_active && (m_q.size() != 0);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * CPB) m_active = 0;
            end
            if (pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1;
                m_t      = 0;
            end
            if (dccm_wen && dccm_waddr == CA) begin
                if (full) m_ovf = 1;
                else m_q.push_back(dccm_wdata[7:0]);
            end
            if (dccm_wen && dccm_waddr == FA && !m_fin) begin
                m_fin  = 1;
                m_code = dccm_wdata;
            end
        end
    endtask

    task automatic cyc(input bit wen, input logic [31:0] a, input logic [31:0] d);
        dccm_wen   = wen;
        dccm_waddr = a;
        dccm_wdata = d;
        @(posedge clk);
        model_step();
        #1;
        dccm_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic rst_cyc();
        rstn = 1'b0;
        cyc(1'b0, '0, '0);
        rstn = 1'b1;
    endtask

    // Per-cycle comparison against the model, plus a mid-bit sampling receiver.
    initial begin
        bit         rx_busy;
        int         rx_t;
        logic [7:0] rx_byte;
        logic       exp_tx;
        rx_busy = 0;
        rx_t    = 0;
        rx_byte = '0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_tx = m_active ? frame_bit(m_byte, m_t / CPB) : 1'b1;
                check("uart_tx", 32'(uart_tx), 32'(exp_tx));
                check("tx_busy", 32'(tx_busy), 32'(m_active || m_q.size() != 0));
                check("console_stall", 32'(console_stall), 32'(m_q.size() == DEPTH));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("finish", 32'(finish), 32'(m_fin));
                check("finish_code", finish_code, m_code);
                if (!rstn) begin
                    rx_busy = 0;
                end else if (!rx_busy) begin
                    if (uart_tx === 1'b0) begin
                        rx_busy = 1;
                        rx_t    = 0;
                    end
                end else begin
                    rx_t++;
                    if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
                        rx_byte[rx_t / CPB - 1] = uart_tx;
                    if (rx_t == 9 * CPB + CPB / 2) begin
                        check("rx_stop_bit", 32'(uart_tx), 32'd1);
                        rx_q.push_back(rx_byte);
                        rx_busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] pat [10];
        logic [7:0] exp_rx [10];
        int         base;
        pat    = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
        exp_rx = '{8'h41, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h3C, 8'hAB, 8'h5C, 8'h12};

        rst_cyc();
        rst_cyc();
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_stall", 32'(console_stall), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_finish", 32'(finish), 32'd0);
        check("reset_finish_code", finish_code, 32'd0);
        idle(3);

        // Single byte 0x41: start bit at T+2, busy drops at T+42.
        store(CA, 32'h41);
        for (int i = 0; i < 40; i++) begin
            idle(1);
            check("frame41_bit", 32'(uart_tx), 32'(pat[i / CPB]));
            if (i == 39) check("busy_T41", 32'(tx_busy), 32'd1);
        end
        idle(1);
        check("busy_T42", 32'(tx_busy), 32'd0);
        idle(3);

        // Fill past capacity: first byte drains immediately, fifth fills, sixth drops.
        for (int i = 0; i < 5; i++) store(CA, 32'h30 + 32'(i));
        check("fill_stall", 32'(console_stall), 32'd1);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        store(CA, 32'h35);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_stall", 32'(console_stall), 32'd1);
        idle(215);
        check("drain_idle", 32'(tx_busy), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Finish is sticky with the first code.
        store(FA, 32'h0);
        check("finish_set", 32'(finish), 32'd1);
        check("finish_code0", finish_code, 32'h0);
        store(FA, 32'h5);
        check("finish_hold", 32'(finish), 32'd1);
        check("finish_code_hold", finish_code, 32'h0);

        // Reset during DATA bit 3 of 0x55 discards the frame.
        store(CA, 32'h55);
        idle(18);
        check("bit3_of_55", 32'(uart_tx), 32'd0);
        base = rx_q.size();
        rst_cyc();
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        check("midrst_finish", 32'(finish), 32'd0);
        idle(45);
        check("midrst_no_rx", 32'(rx_q.size()), 32'(base));

        // Near-miss addresses are ignored.
        store(CA + 32'd4, 32'h7F);
        store(FA + 32'd4, 32'h7F);
        idle(3);
        check("miss_finish", 32'(finish), 32'd0);
        check("miss_busy", 32'(tx_busy), 32'd0);
        check("miss_tx", 32'(uart_tx), 32'd1);

        // Push 0x12 in the IDLE cycle that pops 0xAB with two entries queued.
        store(CA, 32'h3C);
        idle(4);
        store(CA, 32'hAB);
        store(CA, 32'h5C);
        idle(35);
        check("pp_count_before", 32'(dut.u_fifo.o_count), 32'd2);
        check("pp_idle_tx", 32'(uart_tx), 32'd1);
        store(CA, 32'h12);
        check("pp_count_after", 32'(dut.u_fifo.o_count), 32'd2);
        check("pp_start_tx", 32'(uart_tx), 32'd0);
        idle(130);
        check("final_busy", 32'(tx_busy), 32'd0);

        check("rx_count", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) check("rx_byte", 32'(rx_q[i]), 32'(exp_rx[i]));
            else check("rx_byte_missing", 32'hFFFF_FFFF, 32'(exp_rx[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
